// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// mem_pkg
// Shared types for the MEM-stage data-memory access controller.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;
  localparam int REG_IDX_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Everything the memory port and writeback need, latched at accept time
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [REG_IDX_W-1:0]  wd;
    logic                  wreg;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// mem_access_ctrl_if
// EXE-stage inputs, data-memory port and MEM/WB outputs of the MEM stage.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
);

  logic                 exe_valid;
  logic [DATA_W-1:0]    exe_alu_result;
  logic [DATA_W-1:0]    exe_sw_o;
  logic                 exe_DM_read;
  logic                 exe_DM_write;
  logic [REG_IDX_W-1:0] exe_wd;
  logic                 exe_wreg;

  logic                 dm_req;
  logic                 dm_we;
  logic [ADDR_W-1:0]    dm_addr;
  logic [DATA_W-1:0]    dm_wdata;
  logic [DATA_W-1:0]    dm_rdata;
  logic                 dm_ready;

  logic                 mem_stall;
  logic                 mem_valid;
  logic [DATA_W-1:0]    mem_wdata;
  logic [REG_IDX_W-1:0] mem_wd;
  logic                 mem_wreg;
  logic                 mem_err;

  modport master (
    input  exe_valid, exe_alu_result, exe_sw_o, exe_DM_read, exe_DM_write,
           exe_wd, exe_wreg, dm_rdata, dm_ready,
    output dm_req, dm_we, dm_addr, dm_wdata,
           mem_stall, mem_valid, mem_wdata, mem_wd, mem_wreg, mem_err
  );

  modport slave (
    output exe_valid, exe_alu_result, exe_sw_o, exe_DM_read, exe_DM_write,
           exe_wd, exe_wreg, dm_rdata, dm_ready,
    input  dm_req, dm_we, dm_addr, dm_wdata,
           mem_stall, mem_valid, mem_wdata, mem_wd, mem_wreg, mem_err
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// ============================================================================
// mem_timeout_cnt
// Saturating wait counter; hit flags the TIMEOUT-th enabled cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the cycles already waited, so the current cycle is count_q+1
  assign hit = (count_q >= CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// MEM stage: turns EXE loads/stores into req/ready memory transactions,
// stalls the front of the pipe while busy, registers the MEM/WB boundary.
// Optional: MEM_ALIGN_CHECK_EN turns misaligned accesses into errors.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = MEM_DATA_W,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.master bus
);

  mem_state_t           state_q, state_d;
  mem_req_t             req_q, req_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_err_q, mem_err_d;
  logic                 mem_wreg_q, mem_wreg_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [REG_IDX_W-1:0] mem_wd_q, mem_wd_d;

  logic              busy;
  logic              timeout_hit;
  logic              is_mem_op;
  logic              is_illegal;
  logic              misaligned;
  logic [DATA_W-1:0] aligned_addr;

  assign busy         = (state_q == BUSY);
  assign is_mem_op    = bus.exe_DM_read ^ bus.exe_DM_write;
  assign is_illegal   = bus.exe_DM_read & bus.exe_DM_write;
  assign aligned_addr = {bus.exe_alu_result[DATA_W-1:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem_op & (bus.exe_alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy & ~bus.dm_ready),
    .hit    (timeout_hit)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_valid_d = 1'b0;
    mem_err_d   = 1'b0;
    mem_wreg_d  = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_wd_d    = mem_wd_q;

    unique case (state_q)
      IDLE: begin
        if (bus.exe_valid) begin
          mem_wd_d = bus.exe_wd;
          if (is_illegal || misaligned) begin
            mem_valid_d = 1'b1;
            mem_err_d   = 1'b1;
            mem_wdata_d = '0;
          end else if (is_mem_op) begin
            state_d     = BUSY;
            req_d.we    = bus.exe_DM_write;
            req_d.addr  = MEM_ADDR_W'(aligned_addr);
            req_d.wdata = MEM_DATA_W'(bus.exe_sw_o);
            req_d.wd    = bus.exe_wd;
            req_d.wreg  = bus.exe_wreg;
          end else begin
            mem_valid_d = 1'b1;
            mem_wdata_d = bus.exe_alu_result;
            mem_wreg_d  = bus.exe_wreg;
          end
        end
      end
      BUSY: begin
        // dm_ready is checked first so a completion in the timeout cycle is not an error
        if (bus.dm_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b1;
          mem_wd_d    = req_q.wd;
          mem_wdata_d = req_q.we ? '0 : bus.dm_rdata;
          mem_wreg_d  = ~req_q.we & req_q.wreg;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          mem_valid_d = 1'b1;
          mem_err_d   = 1'b1;
          mem_wd_d    = req_q.wd;
          mem_wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= '0;
      mem_wd_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mem_valid_q <= mem_valid_d;
      mem_err_q   <= mem_err_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wd_q    <= mem_wd_d;
    end
  end

  assign bus.dm_req    = busy;
  assign bus.dm_we     = req_q.we;
  assign bus.dm_addr   = ADDR_W'(req_q.addr);
  assign bus.dm_wdata  = DATA_W'(req_q.wdata);
  assign bus.mem_stall = busy & ~bus.dm_ready & ~timeout_hit;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.mem_wreg  = mem_wreg_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wd    = mem_wd_q;

endmodule

`default_nettype wire
